// File: rtl/bomber_status_encoder.sv
// Packs bomber position/lives/bombs into the 14-bit overlay status word.
// Optional macro BOMBER_STATUS_SATURATE_EN clamps out-of-range positions.
module bomber_status_encoder #(
   parameter int POS_WIDTH  = 5,
   parameter int FRAME_SYNC = 1
) (
   input  logic                 i_pclk,
   input  logic                 i_rst,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [POS_WIDTH-1:0] i_pos_x,
   input  logic [POS_WIDTH-1:0] i_pos_y,
   input  logic [1:0]           i_lives,
   input  logic [1:0]           i_bombs,
   input  logic                 i_vsync,
   output logic [13:0]          o_axi_data,
   output logic                 o_update,
   output logic                 o_err
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_CONV_X = 2'd1;
   localparam logic [1:0] S_CONV_Y = 2'd2;
   localparam logic [1:0] S_PEND   = 2'd3;

   localparam logic [POS_WIDTH-1:0] TEN     = POS_WIDTH'(10);
   localparam logic [POS_WIDTH-1:0] MAX_POS = POS_WIDTH'(19);

   logic [1:0]           state_q, state_d;
   logic [POS_WIDTH-1:0] rem_x_q, rem_x_d;
   logic [POS_WIDTH-1:0] rem_y_q, rem_y_d;
   logic                 tens_x_q, tens_x_d;
   logic                 tens_y_q, tens_y_d;
   logic [3:0]           ones_x_q, ones_x_d;
   logic [3:0]           ones_y_q, ones_y_d;
   logic [1:0]           lives_q, lives_d;
   logic [1:0]           bombs_q, bombs_d;
   logic                 vsync_q, vsync_d;
   logic [13:0]          word_q, word_d;
   logic                 pub_q, pub_d;
   logic [13:0]          data_q, data_d;
   logic                 update_q, update_d;
   logic                 err_q, err_d;

   logic accept;
   logic oor_x;
   logic oor_y;
   logic vsync_rise;

   // Ready also stays low while the published word drains out of the
   // two-flop output stage, so a new accept never overlaps an update.
   assign o_ready    = (state_q == S_IDLE) && !i_rst && !pub_q && !update_q;
   assign accept     = i_valid && o_ready;
   assign oor_x      = i_pos_x > MAX_POS;
   assign oor_y      = i_pos_y > MAX_POS;
   assign vsync_rise = i_vsync && !vsync_q;

   assign o_axi_data = data_q;
   assign o_update   = update_q;
   assign o_err      = err_q;

   always_comb begin
      state_d  = state_q;
      rem_x_d  = rem_x_q;
      rem_y_d  = rem_y_q;
      tens_x_d = tens_x_q;
      tens_y_d = tens_y_q;
      ones_x_d = ones_x_q;
      ones_y_d = ones_y_q;
      lives_d  = lives_q;
      bombs_d  = bombs_q;
      vsync_d  = i_vsync;
      word_d   = word_q;
      pub_d    = 1'b0;
      update_d = pub_q;
      data_d   = pub_q ? word_q : data_q;
      err_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
`ifdef BOMBER_STATUS_SATURATE_EN
               rem_x_d  = oor_x ? MAX_POS : i_pos_x;
               rem_y_d  = oor_y ? MAX_POS : i_pos_y;
               tens_x_d = 1'b0;
               tens_y_d = 1'b0;
               lives_d  = i_lives;
               bombs_d  = i_bombs;
               state_d  = S_CONV_X;
`else
               if (oor_x || oor_y) begin
                  err_d = 1'b1;
               end else begin
                  rem_x_d  = i_pos_x;
                  rem_y_d  = i_pos_y;
                  tens_x_d = 1'b0;
                  tens_y_d = 1'b0;
                  lives_d  = i_lives;
                  bombs_d  = i_bombs;
                  state_d  = S_CONV_X;
               end
`endif
            end
         end
         S_CONV_X: begin
            if (rem_x_q >= TEN) begin
               rem_x_d  = rem_x_q - TEN;
               tens_x_d = 1'b1;
            end else begin
               ones_x_d = rem_x_q[3:0];
               state_d  = S_CONV_Y;
            end
         end
         S_CONV_Y: begin
            if (rem_y_q >= TEN) begin
               rem_y_d  = rem_y_q - TEN;
               tens_y_d = 1'b1;
            end else begin
               ones_y_d = rem_y_q[3:0];
               state_d  = S_PEND;
            end
         end
         S_PEND: begin
            if (FRAME_SYNC == 0 || vsync_rise) begin
               word_d  = {bombs_q, lives_q, ones_y_q, tens_y_q,
                          ones_x_q, tens_x_q};
               pub_d   = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_pclk) begin
      if (i_rst) begin
         state_q  <= S_IDLE;
         rem_x_q  <= '0;
         rem_y_q  <= '0;
         tens_x_q <= 1'b0;
         tens_y_q <= 1'b0;
         ones_x_q <= 4'd0;
         ones_y_q <= 4'd0;
         lives_q  <= 2'd0;
         bombs_q  <= 2'd0;
         vsync_q  <= 1'b0;
         word_q   <= 14'h0000;
         pub_q    <= 1'b0;
         data_q   <= 14'h0000;
         update_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rem_x_q  <= rem_x_d;
         rem_y_q  <= rem_y_d;
         tens_x_q <= tens_x_d;
         tens_y_q <= tens_y_d;
         ones_x_q <= ones_x_d;
         ones_y_q <= ones_y_d;
         lives_q  <= lives_d;
         bombs_q  <= bombs_d;
         vsync_q  <= vsync_d;
         word_q   <= word_d;
         pub_q    <= pub_d;
         data_q   <= data_d;
         update_q <= update_d;
         err_q    <= err_d;
      end
   end

endmodule

// File: tb/tb_bomber_status_encoder.sv
// Directed bench for bomber_status_encoder: one free-running instance
// (FRAME_SYNC=0) and one vsync-locked instance (FRAME_SYNC=1).
module tb_bomber_status_encoder;

   logic        clk;
   logic        rst;
   logic        valid0, valid1;
   logic [4:0]  pos_x, pos_y;
   logic [1:0]  lives, bombs;
   logic        vsync;
   logic        ready0, ready1;
   logic [13:0] data0, data1;
   logic        upd0, upd1;
   logic        err0, err1;

   int          n_tests;
   int          n_fail;
   logic [13:0] last0;

   bomber_status_encoder #(.POS_WIDTH(5), .FRAME_SYNC(0)) u_fs0 (
      .i_pclk(clk), .i_rst(rst), .i_valid(valid0), .o_ready(ready0),
      .i_pos_x(pos_x), .i_pos_y(pos_y), .i_lives(lives), .i_bombs(bombs),
      .i_vsync(vsync), .o_axi_data(data0), .o_update(upd0), .o_err(err0)
   );

   bomber_status_encoder #(.POS_WIDTH(5), .FRAME_SYNC(1)) u_fs1 (
      .i_pclk(clk), .i_rst(rst), .i_valid(valid1), .o_ready(ready1),
      .i_pos_x(pos_x), .i_pos_y(pos_y), .i_lives(lives), .i_bombs(bombs),
      .i_vsync(vsync), .o_axi_data(data1), .o_update(upd1), .o_err(err1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic [4:0] x, input logic [4:0] y,
                          input logic [1:0] l, input logic [1:0] b);
      pos_x = x;
      pos_y = y;
      lives = l;
      bombs = b;
   endtask

   task automatic wait_update0(input int max, output bit ok, output int n);
      ok = 1'b0;
      n  = 0;
      while (!ok && n < max) begin
         tick();
         n++;
         if (upd0) ok = 1'b1;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_tests++;
         if (data0 !== 14'h0000 || upd0 !== 1'b0 || ready0 !== 1'b0 ||
             err0 !== 1'b0 || data1 !== 14'h0000 || ready1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: data0=%h upd0=%b rdy0=%b err0=%b data1=%h rdy1=%b, want 0000 0 0 0 0000 0",
                     data0, upd0, ready0, err0, data1, ready1);
         end
      end
      rst = 1'b0;
      #1;
      n_tests++;
      if (ready0 !== 1'b1 || ready1 !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_ready: rdy0=%b rdy1=%b, want 1 1",
                  ready0, ready1);
      end
      last0 = 14'h0000;
   endtask

   task automatic test_free_running;
      logic [13:0] exp_d;
      set_req(5'd13, 5'd7, 2'd2, 2'd3);
      valid0 = 1'b1;
      #1;
      n_tests++;
      if (ready0 !== 1'b1) begin
         n_fail++;
         $display("FAIL fs0_accept_ready: got %b want 1", ready0);
      end
      for (int k = 1; k <= 7; k++) begin
         tick();
         valid0 = 1'b0;
         exp_d = (k >= 6) ? 14'h39C7 : last0;
         n_tests++;
         if (ready0 !== (k == 7) || upd0 !== (k == 6) || data0 !== exp_d) begin
            n_fail++;
            $display("FAIL fs0_cycle%0d: rdy=%b upd=%b data=%h, want %b %b %h",
                     k, ready0, upd0, data0, k == 7, k == 6, exp_d);
         end
      end
      last0 = 14'h39C7;
   endtask

   task automatic test_mid_reset;
      bit stray;
      set_req(5'd13, 5'd7, 2'd2, 2'd3);
      valid0 = 1'b1;
      #1;
      tick();
      valid0 = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      n_tests++;
      if (ready0 !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_ready_low: got %b want 0", ready0);
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         n_tests++;
         if (data0 !== 14'h0000 || upd0 !== 1'b0 || ready0 !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_hold%0d: data=%h upd=%b rdy=%b, want 0000 0 0",
                     k, data0, upd0, ready0);
         end
      end
      rst = 1'b0;
      #1;
      n_tests++;
      if (ready0 !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_release_ready: got %b want 1", ready0);
      end
      stray = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (upd0 || data0 !== 14'h0000) stray = 1'b1;
      end
      n_tests++;
      if (stray) begin
         n_fail++;
         $display("FAIL midrst_aborted: stray update seen, data=%h want 0000",
                  data0);
      end
      last0 = 14'h0000;
   endtask

   task automatic test_boundaries;
      bit          ok;
      int          n;
      logic [9:0]  pos_bits;
      set_req(5'd9, 5'd10, 2'd0, 2'd0);
      valid0 = 1'b1;
      #1;
      tick();
      valid0 = 1'b0;
      wait_update0(20, ok, n);
      pos_bits = data0[9:0];
      n_tests++;
      if (!ok || pos_bits !== 10'h032 || data0 !== 14'h0032) begin
         n_fail++;
         $display("FAIL bound_9_10: ok=%b data=%h, want update with 0032",
                  ok, data0);
      end
      tick();
      set_req(5'd0, 5'd0, 2'd2, 2'd1);
      valid0 = 1'b1;
      #1;
      tick();
      valid0 = 1'b0;
      wait_update0(20, ok, n);
      pos_bits = data0[9:0];
      n_tests++;
      if (!ok || pos_bits !== 10'h000 || data0 !== 14'h1800) begin
         n_fail++;
         $display("FAIL bound_0_0: ok=%b data=%h, want update with 1800",
                  ok, data0);
      end
      tick();
      last0 = 14'h1800;
   endtask

   task automatic test_frame_sync;
      logic [13:0] exp_d;
      vsync = 1'b0;
      set_req(5'd19, 5'd19, 2'd3, 2'd0);
      valid1 = 1'b1;
      #1;
      n_tests++;
      if (ready1 !== 1'b1) begin
         n_fail++;
         $display("FAIL fs1_accept_ready: got %b want 1", ready1);
      end
      for (int k = 1; k <= 23; k++) begin
         tick();
         valid1 = 1'b0;
         if (k == 1 || k == 20) vsync = 1'b1;
         if (k == 2) vsync = 1'b0;
         exp_d = (k >= 22) ? 14'h0E73 : 14'h0000;
         n_tests++;
         if (upd1 !== (k == 22) || data1 !== exp_d || ready1 !== (k == 23)) begin
            n_fail++;
            $display("FAIL fs1_cycle%0d: upd=%b data=%h rdy=%b, want %b %h %b",
                     k, upd1, data1, ready1, k == 22, exp_d, k == 23);
         end
      end
      vsync = 1'b0;
   endtask

   task automatic test_back_to_back;
      bit ok;
      int n;
      set_req(5'd5, 5'd12, 2'd1, 2'd2);
      valid0 = 1'b1;
      #1;
      n_tests++;
      if (ready0 !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_first_ready: got %b want 1", ready0);
      end
      for (int k = 1; k <= 6; k++) begin
         tick();
         set_req(5'(k + 10), 5'(k), 2'(k), 2'(~k));
         n_tests++;
         if (ready0 !== 1'b0 || upd0 !== (k == 6) ||
             (k == 6 && data0 !== 14'h24AA)) begin
            n_fail++;
            $display("FAIL b2b_busy%0d: rdy=%b upd=%b data=%h, want 0 %b 24AA@6",
                     k, ready0, upd0, data0, k == 6);
         end
      end
      tick();
      set_req(5'd18, 5'd3, 2'd0, 2'd1);
      #1;
      n_tests++;
      if (ready0 !== 1'b1 || data0 !== 14'h24AA) begin
         n_fail++;
         $display("FAIL b2b_reaccept: rdy=%b data=%h, want 1 24AA",
                  ready0, data0);
      end
      tick();
      valid0 = 1'b0;
      n_tests++;
      if (ready0 !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_second_taken: rdy=%b want 0", ready0);
      end
      wait_update0(20, ok, n);
      n_tests++;
      if (!ok || n != 5 || data0 !== 14'h10D1) begin
         n_fail++;
         $display("FAIL b2b_second_word: ok=%b cycles=%0d data=%h, want 1 5 10D1",
                  ok, n, data0);
      end
      tick();
      last0 = 14'h10D1;
   endtask

   task automatic test_out_of_range;
      bit ok;
      int n;
      set_req(5'd25, 5'd0, 2'd1, 2'd1);
      valid0 = 1'b1;
      #1;
      n_tests++;
      if (ready0 !== 1'b1) begin
         n_fail++;
         $display("FAIL oor_ready: got %b want 1", ready0);
      end
      tick();
      valid0 = 1'b0;
`ifdef BOMBER_STATUS_SATURATE_EN
      n_tests++;
      if (err0 !== 1'b0) begin
         n_fail++;
         $display("FAIL oor_sat_no_err: err=%b want 0", err0);
      end
      wait_update0(20, ok, n);
      n_tests++;
      if (!ok || data0 !== 14'h1413 || err0 !== 1'b0) begin
         n_fail++;
         $display("FAIL oor_sat_word: ok=%b data=%h err=%b, want 1 1413 0",
                  ok, data0, err0);
      end
      last0 = 14'h1413;
`else
      n_tests++;
      if (err0 !== 1'b1 || ready0 !== 1'b1 || upd0 !== 1'b0) begin
         n_fail++;
         $display("FAIL oor_reject: err=%b rdy=%b upd=%b, want 1 1 0",
                  err0, ready0, upd0);
      end
      ok = 1'b0;
      n  = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (upd0 || err0 || data0 !== last0 || ready0 !== 1'b1) ok = 1'b1;
      end
      n_tests++;
      if (ok) begin
         n_fail++;
         $display("FAIL oor_after: upd=%b err=%b data=%h rdy=%b, want 0 0 %h 1",
                  upd0, err0, data0, ready0, last0);
      end
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst     = 1'b1;
      valid0  = 1'b0;
      valid1  = 1'b0;
      vsync   = 1'b0;
      set_req(5'd0, 5'd0, 2'd0, 2'd0);
      last0   = 14'h0000;
      test_reset();
      test_free_running();
      test_mid_reset();
      test_boundaries();
      test_frame_sync();
      test_back_to_back();
      test_out_of_range();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
